// File: rtl/tlb_miss_sched_pkg.sv
// Shared types for the TLB miss scheduler: walk FSM encoding and performance counter bundle.
package tlb_miss_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    UPD  = 2'd3
  } tlb_miss_sched_state_e;

  localparam int unsigned TLB_PERF_CTR_BITS = 44;

  typedef struct packed {
    logic [TLB_PERF_CTR_BITS-1:0] walks;
    logic [TLB_PERF_CTR_BITS-1:0] merges;
  } tlb_miss_perf_t;

  // A single bank still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_miss_rr_pick.sv
// Rotating-priority encoder: first set request at or above rr_ptr, wrapping to bank 0.
module tlb_miss_rr_pick
  import tlb_miss_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  localparam int unsigned IDX_W = idx_width(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the closest request to rr_ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_BANKS);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tlb_miss_sched.sv
// Funnels TLB misses from several banks onto one page-table walker, merging same-VPN misses
// into the walk in flight and broadcasting the translation to every waiting bank.
module tlb_miss_sched
  import tlb_miss_sched_pkg::*;
#(
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned VPN_WIDTH     = 20,
  parameter int unsigned PPN_WIDTH     = 20,
  parameter int unsigned PERF_CTR_BITS = 44
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BANKS-1:0]           miss_valid_i,
  input  logic [NUM_BANKS*VPN_WIDTH-1:0] miss_vpn_i,
  output logic [NUM_BANKS-1:0]           miss_ready_o,
  output logic                           ptw_req_valid_o,
  output logic [VPN_WIDTH-1:0]           ptw_req_vpn_o,
  input  logic                           ptw_req_ready_i,
  input  logic                           ptw_rsp_valid_i,
  input  logic [PPN_WIDTH-1:0]           ptw_rsp_ppn_i,
  output logic                           ptw_rsp_ready_o,
  output logic [NUM_BANKS-1:0]           upd_valid_o,
  output logic [VPN_WIDTH-1:0]           upd_vpn_o,
  output logic [PPN_WIDTH-1:0]           upd_ppn_o,
  input  logic [NUM_BANKS-1:0]           upd_ready_i,
  output logic                           busy_o,
  output logic [PERF_CTR_BITS-1:0]       perf_walks_o,
  output logic [PERF_CTR_BITS-1:0]       perf_merges_o
);

  localparam int unsigned IDX_W = idx_width(NUM_BANKS);
  localparam int unsigned CNT_W = $clog2(NUM_BANKS + 1);

  tlb_miss_sched_state_e    state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [NUM_BANKS-1:0]     wait_mask;
  logic [VPN_WIDTH-1:0]     vpn_r;
  logic [PPN_WIDTH-1:0]     ppn_r;
  logic [PERF_CTR_BITS-1:0] perf_walks;
  logic [PERF_CTR_BITS-1:0] perf_merges;

  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [IDX_W-1:0]     next_ptr;
  logic [VPN_WIDTH-1:0] bank_vpn [NUM_BANKS];
  logic [VPN_WIDTH-1:0] cmp_vpn;
  logic [NUM_BANKS-1:0] match;
  logic [NUM_BANKS-1:0] accept_mask;
  logic [CNT_W-1:0]     accept_cnt;
  logic [NUM_BANKS-1:0] upd_left;

  tlb_miss_rr_pick #(.NUM_BANKS(NUM_BANKS)) u_pick (
    .req         (miss_valid_i),
    .rr_ptr      (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // In IDLE the granted VPN defines the walk; afterwards late misses are matched against vpn_r.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_vpn[b] = miss_vpn_i[b*VPN_WIDTH +: VPN_WIDTH];
    end
    cmp_vpn = (state == IDLE) ? bank_vpn[grant_idx] : vpn_r;
    for (int b = 0; b < NUM_BANKS; b++) begin
      match[b] = miss_valid_i[b] && (bank_vpn[b] == cmp_vpn);
    end
    case (state)
      IDLE:      accept_mask = grant_valid ? match : '0;
      REQ, WAIT: accept_mask = match & ~wait_mask;
      default:   accept_mask = '0;
    endcase
    accept_cnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      accept_cnt = accept_cnt + CNT_W'(accept_mask[b]);
    end
    next_ptr = IDX_W'((int'(grant_idx) + 1) % NUM_BANKS);
    upd_left = wait_mask & ~upd_ready_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wait_mask   <= '0;
      vpn_r       <= '0;
      ppn_r       <= '0;
      perf_walks  <= '0;
      perf_merges <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            vpn_r       <= bank_vpn[grant_idx];
            wait_mask   <= accept_mask;
            rr_ptr      <= next_ptr;
            perf_walks  <= perf_walks + PERF_CTR_BITS'(1);
            perf_merges <= perf_merges + PERF_CTR_BITS'(accept_cnt - CNT_W'(1));
            state       <= REQ;
          end
        end
        REQ: begin
          wait_mask   <= wait_mask | accept_mask;
          perf_merges <= perf_merges + PERF_CTR_BITS'(accept_cnt);
          if (ptw_req_ready_i) state <= WAIT;
        end
        WAIT: begin
          wait_mask   <= wait_mask | accept_mask;
          perf_merges <= perf_merges + PERF_CTR_BITS'(accept_cnt);
          if (ptw_rsp_valid_i) begin
            ppn_r <= ptw_rsp_ppn_i;
            state <= UPD;
          end
        end
        default: begin
          wait_mask <= upd_left;
          if (upd_left == '0) state <= IDLE;
        end
      endcase
    end
  end

  assign miss_ready_o    = accept_mask;
  assign ptw_req_valid_o = (state == REQ);
  assign ptw_req_vpn_o   = vpn_r;
  assign ptw_rsp_ready_o = (state == WAIT);
  assign upd_valid_o     = (state == UPD) ? wait_mask : '0;
  assign upd_vpn_o       = vpn_r;
  assign upd_ppn_o       = ppn_r;
  assign busy_o          = (state != IDLE);
  assign perf_walks_o    = perf_walks;
  assign perf_merges_o   = perf_merges;

endmodule

// File: tb/tb_tlb_miss_sched.sv
// Scoreboard bench for tlb_miss_sched: each accepted miss pushes the walk it should produce,
// and every update broadcast pops and compares against it.
module tb_tlb_miss_sched;

  localparam int NB = 4;
  localparam int VW = 20;
  localparam int PW = 20;
  localparam int CB = 44;

  logic             clk = 1'b0;
  logic             reset;
  logic [NB-1:0]    miss_valid;
  logic [NB*VW-1:0] miss_vpn;
  logic [NB-1:0]    miss_ready;
  logic             ptw_req_valid;
  logic [VW-1:0]    ptw_req_vpn;
  logic             ptw_req_ready;
  logic             ptw_rsp_valid;
  logic [PW-1:0]    ptw_rsp_ppn;
  logic             ptw_rsp_ready;
  logic [NB-1:0]    upd_valid;
  logic [VW-1:0]    upd_vpn;
  logic [PW-1:0]    upd_ppn;
  logic [NB-1:0]    upd_ready;
  logic             busy;
  logic [CB-1:0]    perf_walks;
  logic [CB-1:0]    perf_merges;

  typedef struct {
    logic [VW-1:0] vpn;
    logic [PW-1:0] ppn;
    logic [NB-1:0] mask;
  } walk_t;

  walk_t         exp_q[$];
  logic [VW-1:0] bank_vpn [NB];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  tlb_miss_sched #(
    .NUM_BANKS(NB), .VPN_WIDTH(VW), .PPN_WIDTH(PW), .PERF_CTR_BITS(CB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .miss_valid_i    (miss_valid),
    .miss_vpn_i      (miss_vpn),
    .miss_ready_o    (miss_ready),
    .ptw_req_valid_o (ptw_req_valid),
    .ptw_req_vpn_o   (ptw_req_vpn),
    .ptw_req_ready_i (ptw_req_ready),
    .ptw_rsp_valid_i (ptw_rsp_valid),
    .ptw_rsp_ppn_i   (ptw_rsp_ppn),
    .ptw_rsp_ready_o (ptw_rsp_ready),
    .upd_valid_o     (upd_valid),
    .upd_vpn_o       (upd_vpn),
    .upd_ppn_o       (upd_ppn),
    .upd_ready_i     (upd_ready),
    .busy_o          (busy),
    .perf_walks_o    (perf_walks),
    .perf_merges_o   (perf_merges)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NB-1:0] valid);
    miss_valid = valid;
    for (int b = 0; b < NB; b++) miss_vpn[b*VW +: VW] = bank_vpn[b];
    #1;
  endtask

  task automatic doReset();
    reset         = 1'b1;
    miss_valid    = '0;
    miss_vpn      = '0;
    ptw_req_ready = 1'b0;
    ptw_rsp_valid = 1'b0;
    ptw_rsp_ppn   = '0;
    upd_ready     = '0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_miss_ready"}, 64'(miss_ready), 64'(0));
    checkOutput({tag, "_req_valid"}, 64'(ptw_req_valid), 64'(0));
    checkOutput({tag, "_req_vpn"}, 64'(ptw_req_vpn), 64'(0));
    checkOutput({tag, "_rsp_ready"}, 64'(ptw_rsp_ready), 64'(0));
    checkOutput({tag, "_upd_valid"}, 64'(upd_valid), 64'(0));
    checkOutput({tag, "_upd_vpn"}, 64'(upd_vpn), 64'(0));
    checkOutput({tag, "_upd_ppn"}, 64'(upd_ppn), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_walks"}, 64'(perf_walks), 64'(0));
    checkOutput({tag, "_merges"}, 64'(perf_merges), 64'(0));
  endtask

  // Present misses in IDLE, expect exp_mask accepted, record the walk, and advance into REQ.
  task automatic acceptMiss(input string tag, input logic [NB-1:0] valid, input logic [NB-1:0] exp_mask,
                            input logic [VW-1:0] vpn, input logic [PW-1:0] ppn, input bit keep);
    walk_t w;
    applyStimulus(valid);
    checkOutput({tag, "_grant"}, 64'(miss_ready), 64'(exp_mask));
    w.vpn  = vpn;
    w.ppn  = ppn;
    w.mask = exp_mask;
    exp_q.push_back(w);
    tick();
    if (keep) begin
      for (int b = 0; b < NB; b++) if (exp_mask[b]) bank_vpn[b] = bank_vpn[b] + 20'h1;
      applyStimulus(valid);
    end else begin
      applyStimulus(valid & ~exp_mask);
    end
  endtask

  task automatic issueReq(input int stall);
    int n;
    n = 0;
    ptw_req_ready = (stall == 0);
    while (!ptw_req_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("req_valid", 64'(ptw_req_valid), 64'(1));
    if (exp_q.size() == 0) begin
      checkOutput("sb_req_nonempty", 64'(exp_q.size()), 64'(1));
      return;
    end
    checkOutput("req_vpn", 64'(ptw_req_vpn), 64'(exp_q[0].vpn));
    checkOutput("req_rsp_ready", 64'(ptw_rsp_ready), 64'(0));
    for (int i = 1; i < stall; i++) begin
      tick();
      checkOutput("stall_valid", 64'(ptw_req_valid), 64'(1));
      checkOutput("stall_vpn", 64'(ptw_req_vpn), 64'(exp_q[0].vpn));
    end
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
  endtask

  task automatic respond(input int delay);
    checkOutput("rsp_ready", 64'(ptw_rsp_ready), 64'(1));
    repeat (delay) tick();
    ptw_rsp_valid = 1'b1;
    ptw_rsp_ppn   = (exp_q.size() != 0) ? exp_q[0].ppn : '0;
    tick();
    ptw_rsp_valid = 1'b0;
    ptw_rsp_ppn   = '0;
    #1;
  endtask

  task automatic finishUpd();
    walk_t w;
    if (exp_q.size() == 0) begin
      checkOutput("sb_upd_nonempty", 64'(exp_q.size()), 64'(1));
      return;
    end
    w = exp_q.pop_front();
    checkOutput("upd_valid", 64'(upd_valid), 64'(w.mask));
    checkOutput("upd_vpn", 64'(upd_vpn), 64'(w.vpn));
    checkOutput("upd_ppn", 64'(upd_ppn), 64'(w.ppn));
    checkOutput("upd_miss_ready", 64'(miss_ready), 64'(0));
    upd_ready = '1;
    tick();
    upd_ready = '0;
    #1;
    checkOutput("upd_done_busy", 64'(busy), 64'(0));
    checkOutput("upd_done_valid", 64'(upd_valid), 64'(0));
  endtask

  task automatic serviceWalk(input int stall, input int delay);
    issueReq(stall);
    respond(delay);
    finishUpd();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    walk_t w;
    for (int b = 0; b < NB; b++) bank_vpn[b] = '0;
    doReset();
    checkZero("reset");

    // Single miss from bank 2, response three WAIT cycles later.
    bank_vpn[2] = 20'h12345;
    acceptMiss("single", 4'b0100, 4'b0100, 20'h12345, 20'hABCDE, 1'b0);
    serviceWalk(0, 2);
    checkOutput("single_walks", 64'(perf_walks), 64'(1));
    checkOutput("single_merges", 64'(perf_merges), 64'(0));

    // Round robin with every bank continuously requesting distinct VPNs.
    doReset();
    for (int b = 0; b < NB; b++) bank_vpn[b] = 20'h10000 + 20'(b * 'h100);
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NB;
      acceptMiss("rr", 4'b1111, 4'(1 << g), bank_vpn[g], 20'(20'h50000 + k), 1'b1);
      checkOutput("rr_hold", 64'(miss_ready), 64'(0));
      serviceWalk(0, 1);
    end
    checkOutput("rr_walks", 64'(perf_walks), 64'(5));
    checkOutput("rr_merges", 64'(perf_merges), 64'(0));

    // Same VPN from banks 0 and 3 in one cycle; rr_ptr=1 so bank 3 wins and bank 0 merges.
    bank_vpn[0] = 20'h00042;
    bank_vpn[3] = 20'h00042;
    acceptMiss("merge", 4'b1001, 4'b1001, 20'h00042, 20'h0C0DE, 1'b0);
    serviceWalk(0, 1);
    checkOutput("merge_walks", 64'(perf_walks), 64'(6));
    checkOutput("merge_merges", 64'(perf_merges), 64'(1));

    // Late merge in WAIT: bank 1 joins, bank 2 (other VPN) stalls until the next IDLE.
    bank_vpn[0] = 20'h00777;
    acceptMiss("late", 4'b0001, 4'b0001, 20'h00777, 20'h0F00D, 1'b0);
    issueReq(0);
    bank_vpn[1] = 20'h00777;
    bank_vpn[2] = 20'h00888;
    applyStimulus(4'b0110);
    checkOutput("late_merge_ready", 64'(miss_ready), 64'(4'b0010));
    if (exp_q.size() != 0) exp_q[0].mask = exp_q[0].mask | 4'b0010;
    tick();
    applyStimulus(4'b0100);
    checkOutput("late_stall", 64'(miss_ready), 64'(0));
    respond(0);
    bank_vpn[3] = 20'h00777;
    applyStimulus(4'b1100);
    checkOutput("upd_no_merge", 64'(miss_ready), 64'(0));
    applyStimulus(4'b0100);
    finishUpd();
    acceptMiss("late_next", 4'b0100, 4'b0100, 20'h00888, 20'h0BEEF, 1'b0);
    serviceWalk(0, 0);
    checkOutput("late_walks", 64'(perf_walks), 64'(8));
    checkOutput("late_merges", 64'(perf_merges), 64'(2));

    // PTW backpressure, then staggered update acceptance; rr_ptr=3 wraps to bank 0.
    bank_vpn[0] = 20'h00ABC;
    bank_vpn[1] = 20'h00ABC;
    acceptMiss("bp", 4'b0011, 4'b0011, 20'h00ABC, 20'h01234, 1'b0);
    issueReq(5);
    respond(0);
    w = exp_q.pop_front();
    checkOutput("bp_upd_valid", 64'(upd_valid), 64'(w.mask));
    checkOutput("bp_upd_ppn", 64'(upd_ppn), 64'(w.ppn));
    upd_ready = 4'b0001;
    tick();
    upd_ready = 4'b0000;
    #1;
    checkOutput("bp_t0_valid", 64'(upd_valid), 64'(4'b0010));
    checkOutput("bp_t0_busy", 64'(busy), 64'(1));
    tick();
    checkOutput("bp_t1_valid", 64'(upd_valid), 64'(4'b0010));
    upd_ready = 4'b0010;
    tick();
    upd_ready = 4'b0000;
    #1;
    checkOutput("bp_t3_busy", 64'(busy), 64'(0));
    checkOutput("bp_t3_valid", 64'(upd_valid), 64'(0));

    // Reset during WAIT abandons the walk; the next grant restarts from bank 0.
    bank_vpn[1] = 20'h00999;
    acceptMiss("rst", 4'b0010, 4'b0010, 20'h00999, 20'h05555, 1'b0);
    issueReq(0);
    checkOutput("rst_wait_busy", 64'(busy), 64'(1));
    reset         = 1'b1;
    ptw_rsp_valid = 1'b1;
    ptw_rsp_ppn   = 20'h05555;
    tick();
    checkZero("rst_wait");
    reset         = 1'b0;
    ptw_rsp_valid = 1'b0;
    ptw_rsp_ppn   = '0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_no_upd", 64'(upd_valid), 64'(0));
    end
    bank_vpn[0] = 20'h00AAA;
    bank_vpn[2] = 20'h00BBB;
    acceptMiss("rst_after", 4'b0101, 4'b0001, 20'h00AAA, 20'h06666, 1'b0);
    applyStimulus(4'b0000);
    serviceWalk(0, 1);
    checkOutput("rst_after_walks", 64'(perf_walks), 64'(1));
    checkOutput("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
